mem_port_arbiter: RTL and testbench

//   Shares the single 128-bit iomem main-memory port between the instruction-fetch (I) and data (D) requesters.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the iomem port arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; fixed D-priority otherwise.
package mem_arb_pkg;

  localparam int unsigned BLOCK_SIZE = 128;
  localparam int unsigned NUMS_BYTE  = BLOCK_SIZE / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker between the I and D requesters.
// ARB_ROUND_ROBIN_EN: ties go to the requester that did not win last; otherwise D wins ties.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic    i_valid_i,
  input  logic    d_valid_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  req_id_e last_grant_i,
`endif
  output req_id_e winner_o
);

  always_comb begin
    winner_o = REQ_I;
    if (i_valid_i && d_valid_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
`else
      winner_o = REQ_D;
`endif
    end else if (d_valid_i) begin
      winner_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the 128-bit iomem port between I-fetch and data requesters, one transaction at a time.
// ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (adds a last-grant flop).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_valid_i,
  input  logic [ADDR_W-1:0]     i_addr_i,
  output logic                  i_ready_o,
  output logic [BLOCK_SIZE-1:0] i_rdata_o,
  input  logic                  d_valid_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [NUMS_BYTE-1:0]  d_wstrb_i,
  input  logic [BLOCK_SIZE-1:0] d_wdata_i,
  output logic                  d_ready_o,
  output logic [BLOCK_SIZE-1:0] d_rdata_o,
  output logic                  mem_valid_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [NUMS_BYTE-1:0]  mem_wstrb_o,
  output logic [BLOCK_SIZE-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [BLOCK_SIZE-1:0] mem_rdata_i,
  output logic                  grant_o,
  output logic                  busy_o
);

  arb_state_e state_q, state_d;
  req_id_e    grant_q, grant_d;
  req_id_e    winner;
  logic       mem_valid_q, mem_valid_d;
  logic       i_ready_q, i_ready_d;
  logic       d_ready_q, d_ready_d;

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUMS_BYTE-1:0]  wstrb_q, wstrb_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_grant_q, last_grant_d;
`endif

  arb_pick2 u_pick (
    .i_valid_i    (i_valid_i),
    .d_valid_i    (d_valid_i),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .winner_o     (winner)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_valid_d = mem_valid_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_valid_i || d_valid_i) begin
          state_d     = BUS;
          mem_valid_d = 1'b1;
          grant_d     = winner;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
          if (winner == REQ_D) begin
            addr_d  = d_addr_i;
            wstrb_d = d_wstrb_i;
            wdata_d = d_wdata_i;
          end else begin
            addr_d  = i_addr_i;
            wstrb_d = '0;
            wdata_d = '0;
          end
        end
      end
      BUS: begin
        if (mem_ready_i) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          // Writes return zero data to the requester.
          rdata_d     = (wstrb_q == '0) ? mem_rdata_i : '0;
          i_ready_d   = (grant_q == REQ_I);
          d_ready_d   = (grant_q == REQ_D);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= REQ_I;
      mem_valid_q <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_I;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    wstrb_q <= wstrb_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // Unreset data registers are masked so every output reads zero out of reset.
  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_valid_q ? addr_q  : '0;
  assign mem_wstrb_o = mem_valid_q ? wstrb_q : '0;
  assign mem_wdata_o = mem_valid_q ? wdata_q : '0;
  assign i_ready_o   = i_ready_q;
  assign d_ready_o   = d_ready_q;
  assign i_rdata_o   = i_ready_q ? rdata_q : '0;
  assign d_rdata_o   = d_ready_q ? rdata_q : '0;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);

  a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == BUS) |-> ((grant_q == REQ_D) ? d_valid_i : i_valid_i))
    else $error("requester dropped valid while its transaction was on the bus");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; honours ARB_ROUND_ROBIN_EN for tie expectations.
module tb_mem_port_arbiter;

  logic         clk_i;
  logic         rst_i;
  logic         i_valid_i;
  logic [31:0]  i_addr_i;
  logic         i_ready_o;
  logic [127:0] i_rdata_o;
  logic         d_valid_i;
  logic [31:0]  d_addr_i;
  logic [15:0]  d_wstrb_i;
  logic [127:0] d_wdata_i;
  logic         d_ready_o;
  logic [127:0] d_rdata_o;
  logic         mem_valid_o;
  logic [31:0]  mem_addr_o;
  logic [15:0]  mem_wstrb_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i;
  logic [127:0] mem_rdata_i;
  logic         grant_o;
  logic         busy_o;

  int n_chk;
  int n_bad;

  mem_port_arbiter #(
    .ADDR_W (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_valid_i   (i_valid_i),
    .i_addr_i    (i_addr_i),
    .i_ready_o   (i_ready_o),
    .i_rdata_o   (i_rdata_o),
    .d_valid_i   (d_valid_i),
    .d_addr_i    (d_addr_i),
    .d_wstrb_i   (d_wstrb_i),
    .d_wdata_i   (d_wdata_i),
    .d_ready_o   (d_ready_o),
    .d_rdata_o   (d_rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Runs one transaction whose request is already presented; ends on the IDLE bubble cycle.
  task automatic xact(input string tag, input logic exp_d, input int lat,
                      input logic [127:0] rd, input logic [31:0] exp_addr,
                      input logic [15:0] exp_wstrb, input logic [127:0] exp_wdata,
                      input logic drop);
    logic [127:0] exp_rd;
    exp_rd = (exp_d && exp_wstrb != 16'h0) ? 128'h0 : rd;
    step();
    check_eq({tag, "_busy"},  {127'h0, busy_o},      128'h1);
    check_eq({tag, "_grant"}, {127'h0, grant_o},     {127'h0, exp_d});
    check_eq({tag, "_mval"},  {127'h0, mem_valid_o}, 128'h1);
    check_eq({tag, "_addr"},  {96'h0, mem_addr_o},   {96'h0, exp_addr});
    check_eq({tag, "_wstrb"}, {112'h0, mem_wstrb_o}, {112'h0, exp_wstrb});
    check_eq({tag, "_wdata"}, mem_wdata_o,           exp_wdata);
    repeat (lat - 1) step();
    mem_ready_i = 1'b1;
    mem_rdata_i = rd;
    step();
    check_eq({tag, "_irdy"},  {127'h0, i_ready_o},   {127'h0, !exp_d});
    check_eq({tag, "_drdy"},  {127'h0, d_ready_o},   {127'h0, exp_d});
    check_eq({tag, "_mdrop"}, {127'h0, mem_valid_o}, 128'h0);
    if (exp_d) check_eq({tag, "_drd"}, d_rdata_o, exp_rd);
    else       check_eq({tag, "_ird"}, i_rdata_o, exp_rd);
    mem_ready_i = 1'b0;
    mem_rdata_i = 128'h0;
    if (drop) begin
      if (exp_d) d_valid_i = 1'b0;
      else       i_valid_i = 1'b0;
    end
    step();
    check_eq({tag, "_idle"},  {127'h0, busy_o},      128'h0);
    check_eq({tag, "_pulse"}, {126'h0, i_ready_o, d_ready_o}, 128'h0);
  endtask

  logic exp_hold [4];

  initial begin
    n_chk       = 0;
    n_bad       = 0;
    rst_i       = 1'b1;
    i_valid_i   = 1'b0;
    i_addr_i    = 32'h0;
    d_valid_i   = 1'b0;
    d_addr_i    = 32'h0;
    d_wstrb_i   = 16'h0;
    d_wdata_i   = 128'h0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 128'h0;
    step();
    step();
    check_eq("rst_mval",  {127'h0, mem_valid_o}, 128'h0);
    check_eq("rst_busy",  {127'h0, busy_o},      128'h0);
    check_eq("rst_grant", {127'h0, grant_o},     128'h0);
    check_eq("rst_rdy",   {126'h0, i_ready_o, d_ready_o}, 128'h0);
    check_eq("rst_ird",   i_rdata_o, 128'h0);
    check_eq("rst_drd",   d_rdata_o, 128'h0);
    check_eq("rst_addr",  {96'h0, mem_addr_o}, 128'h0);
    rst_i = 1'b0;
    step();

    // I-only read, mem_ready 16 cycles after mem_valid_o (ready pulse at t=18).
    i_valid_i = 1'b1;
    i_addr_i  = 32'h8000_0010;
    xact("iread", 1'b0, 17, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
         32'h8000_0010, 16'h0, 128'h0, 1'b1);

    // D write, mem_ready immediate.
    d_valid_i = 1'b1;
    d_addr_i  = 32'h8000_0020;
    d_wstrb_i = 16'hFFFF;
    d_wdata_i = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    xact("dwrite", 1'b1, 1, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff,
         32'h8000_0020, 16'hFFFF, 128'hdead_beef_0000_1111_2222_3333_4444_5555, 1'b1);

    // Spurious mem_ready in IDLE is ignored.
    mem_ready_i = 1'b1;
    mem_rdata_i = 128'h5a5a;
    step();
    step();
    check_eq("spur_busy", {127'h0, busy_o},      128'h0);
    check_eq("spur_mval", {127'h0, mem_valid_o}, 128'h0);
    check_eq("spur_rdy",  {126'h0, i_ready_o, d_ready_o}, 128'h0);
    mem_ready_i = 1'b0;
    mem_rdata_i = 128'h0;
    step();
    check_eq("spur_after", {126'h0, i_ready_o, d_ready_o}, 128'h0);

    // Reset during BUS aborts silently; a fresh request then completes.
    i_valid_i = 1'b1;
    i_addr_i  = 32'h8000_0040;
    step();
    check_eq("abort_mval", {127'h0, mem_valid_o}, 128'h1);
    step();
    #1;
    rst_i = 1'b1;
    #1;
    check_eq("abort_async", {127'h0, mem_valid_o}, 128'h0);
    check_eq("abort_busy",  {127'h0, busy_o},      128'h0);
    i_valid_i   = 1'b0;
    mem_ready_i = 1'b1;
    step();
    step();
    check_eq("abort_rdy", {126'h0, i_ready_o, d_ready_o}, 128'h0);
    mem_ready_i = 1'b0;
    rst_i       = 1'b0;
    step();
    check_eq("abort_norsp", {126'h0, i_ready_o, d_ready_o}, 128'h0);
    d_valid_i = 1'b1;
    d_addr_i  = 32'h8000_0050;
    d_wstrb_i = 16'h0;
    d_wdata_i = 128'h0;
    xact("postrst", 1'b1, 2, 128'h1111_2222, 32'h8000_0050, 16'h0, 128'h0, 1'b1);

    // Tie from fresh reset: D first (last grant starts at I), then I.
    reset_dut();
    i_valid_i = 1'b1;
    i_addr_i  = 32'h8000_0100;
    d_valid_i = 1'b1;
    d_addr_i  = 32'h8000_0200;
    d_wstrb_i = 16'h0;
    xact("tie_d", 1'b1, 3, 128'haaaa_0001, 32'h8000_0200, 16'h0, 128'h0, 1'b1);
    xact("tie_i", 1'b0, 2, 128'hbbbb_0002, 32'h8000_0100, 16'h0, 128'h0, 1'b1);

    // Both held for four transactions.
    reset_dut();
`ifdef ARB_ROUND_ROBIN_EN
    exp_hold = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_hold = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    i_valid_i = 1'b1;
    i_addr_i  = 32'h8000_0300;
    d_valid_i = 1'b1;
    d_addr_i  = 32'h8000_0400;
    d_wstrb_i = 16'h00F0;
    d_wdata_i = 128'h0c0c_0c0c;
    for (int k = 0; k < 4; k++) begin
      xact($sformatf("hold%0d", k), exp_hold[k], 1 + k, 128'h7700 + 128'(k),
           exp_hold[k] ? 32'h8000_0400 : 32'h8000_0300,
           exp_hold[k] ? 16'h00F0 : 16'h0,
           exp_hold[k] ? 128'h0c0c_0c0c : 128'h0, 1'b0);
    end
    i_valid_i = 1'b0;
    d_valid_i = 1'b0;
    step();
    step();
    check_eq("end_busy", {127'h0, busy_o}, 128'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
